spi_ram_arbiter: RTL

SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

---
 rtl/spi_ram_arb_pkg.sv | 28 ++
 rtl/rr_arbiter_2.sv | 54 +++++
 rtl/spi_ram_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// spi_ram_arb_pkg
// Shared definitions for the two-requester SPI RAM arbiter:
//   - default width/timeout constants
//   - RAM command control codes (top two bits of ram_din)
//   - FSM state encoding
// -----------------------------------------------------------------------------
package spi_ram_arb_pkg;

   localparam int DEF_ADDR_SIZE      = 8;
   localparam int DEF_MEM_WIDTH      = 8;
   localparam int DEF_TIMEOUT_CYCLES = 15;

   typedef enum logic [1:0] {
      WR_ADDR = 2'b00,
      WR_DATA = 2'b01,
      RD_ADDR = 2'b10,
      RD_DATA = 2'b11
   } ctrl_e;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ADDR    = 2'd1,
      S_DATA    = 2'd2,
      S_WAIT_RD = 2'd3
   } state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// -----------------------------------------------------------------------------
// rr_arbiter_2
// Two-way round-robin selector. Holds the index of the requester granted
// last; when both request, the other one wins. After reset the pointer
// says "requester 1 was last", so requester 0 has priority.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   req_i[1:0]    live request lines
//   gnt_valid_i   a grant is being issued this cycle (pointer update strobe)
//   gnt_idx_i     index of the requester being granted
//   any_o         at least one request is present
//   winner_o      index of the selected requester (valid when any_o)
// -----------------------------------------------------------------------------
module rr_arbiter_2
   import spi_ram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       gnt_valid_i,
   input  logic       gnt_idx_i,
   output logic       any_o,
   output logic       winner_o
);

   logic last_q, last_d;

   always_comb begin
      last_d = last_q;
      if (gnt_valid_i) begin
         last_d = gnt_idx_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

   always_comb begin
      any_o    = |req_i;
      winner_o = 1'b0;
      case (req_i)
         2'b01:   winner_o = 1'b0;
         2'b10:   winner_o = 1'b1;
         2'b11:   winner_o = ~last_q;
         default: winner_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/spi_ram_arbiter.sv
// -----------------------------------------------------------------------------
// spi_ram_arbiter
// Arbitrates two requesters onto a single serial-RAM command port. Each
// access is two command beats: an address beat then a data beat
// (ram_din = {ctrl[1:0], payload}). Writes complete in the cycle after the
// data beat; reads wait for ram_tx_valid and return ram_dout on rdata.
//
// Handshake: a requester raises req with we/addr/wdata and holds them until
// it sees its one-cycle gnt pulse. done pulses once per access, one-hot by
// requester. If req is still high when the FSM is back in IDLE it is a new
// request.
//
// Optional feature: define SPI_RAM_ARB_TIMEOUT_EN to abandon a read after
// TIMEOUT_CYCLES waiting edges; done and err then pulse together, rdata=0.
// Without it err is tied low and a read waits indefinitely.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   req/req_we        per-requester request and write(1)/read(0)
//   req_addr/wdata    per-requester address and write data
//   gnt, done         one-hot grant / completion pulses
//   rdata, err        read data (held), timeout flag
//   ram_din           RAM command, ram_rx_valid its strobe
//   ram_dout          RAM read data, ram_tx_valid its strobe
//   dbg_state_o       current FSM state for observation
// -----------------------------------------------------------------------------
module spi_ram_arbiter
   import spi_ram_arb_pkg::*;
#(
   parameter int ADDR_SIZE      = DEF_ADDR_SIZE,
   parameter int MEM_WIDTH      = DEF_MEM_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [1:0]                          req,
   input  logic [1:0]                          req_we,
   input  logic [1:0][ADDR_SIZE-1:0]           req_addr,
   input  logic [1:0][MEM_WIDTH-1:0]           req_wdata,
   output logic [1:0]                          gnt,
   output logic [1:0]                          done,
   output logic [MEM_WIDTH-1:0]                rdata,
   output logic                                err,
   output logic [MEM_WIDTH+1:0]                ram_din,
   output logic                                ram_rx_valid,
   input  logic [MEM_WIDTH-1:0]                ram_dout,
   input  logic                                ram_tx_valid,
   output logic [1:0]                          dbg_state_o
);

   localparam logic [1:0] IDLE    = S_IDLE;
   localparam logic [1:0] ADDR    = S_ADDR;
   localparam logic [1:0] DATA    = S_DATA;
   localparam logic [1:0] WAIT_RD = S_WAIT_RD;

   logic [1:0]           state_q, state_d;
   logic                 winner_q, winner_d;
   logic                 we_q, we_d;
   logic [ADDR_SIZE-1:0] addr_q, addr_d;
   logic [MEM_WIDTH-1:0] wdata_q, wdata_d;
   logic [1:0]           done_q, done_d;
   logic [MEM_WIDTH-1:0] rdata_q, rdata_d;
   logic                 err_q, err_d;
   logic                 arb_any, arb_winner;
   logic [1:0]           winner_oh;
   logic                 timeout_hit;
   logic [1:0]           ctrl;

   assign winner_oh = winner_q ? 2'b10 : 2'b01;

   // The pointer moves when the grant is actually presented (ADDR cycle).
   rr_arbiter_2 u_rr (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req),
      .gnt_valid_i (state_q == ADDR),
      .gnt_idx_i   (winner_q),
      .any_o       (arb_any),
      .winner_o    (arb_winner)
   );

`ifdef SPI_RAM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counts waiting edges; the TIMEOUT_CYCLES-th edge without data fires.
   assign timeout_hit = (state_q == WAIT_RD) && !ram_tx_valid &&
                        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = '0;
      if ((state_q == WAIT_RD) && !ram_tx_valid && !timeout_hit) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      done_d   = 2'b00;
      rdata_d  = rdata_q;
      err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_any) begin
               winner_d = arb_winner;
               we_d     = req_we[arb_winner];
               addr_d   = req_addr[arb_winner];
               wdata_d  = req_wdata[arb_winner];
               state_d  = ADDR;
            end
         end
         ADDR: state_d = DATA;
         DATA: begin
            if (we_q) begin
               done_d  = winner_oh;
               state_d = IDLE;
            end else begin
               state_d = WAIT_RD;
            end
         end
         WAIT_RD: begin
            if (ram_tx_valid) begin
               rdata_d = ram_dout;
               done_d  = winner_oh;
               state_d = IDLE;
            end else if (timeout_hit) begin
               rdata_d = '0;
               done_d  = winner_oh;
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         winner_q <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         done_q   <= 2'b00;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         winner_q <= winner_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         done_q   <= done_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // Command beats are a pure decode of registered state, so they drop to
   // zero as soon as reset asserts.
   always_comb begin
      gnt          = 2'b00;
      ram_rx_valid = 1'b0;
      ram_din      = '0;
      ctrl         = WR_ADDR;
      case (state_q)
         ADDR: begin
            gnt          = winner_oh;
            ram_rx_valid = 1'b1;
            ctrl         = we_q ? WR_ADDR : RD_ADDR;
            ram_din      = {ctrl, MEM_WIDTH'(addr_q)};
         end
         DATA: begin
            ram_rx_valid = 1'b1;
            ctrl         = we_q ? WR_DATA : RD_DATA;
            ram_din      = {ctrl, (we_q ? wdata_q : {MEM_WIDTH{1'b0}})};
         end
         default: begin
            gnt = 2'b00;
         end
      endcase
   end

   assign done        = done_q;
   assign rdata       = rdata_q;
   assign err         = err_q;
   assign dbg_state_o = state_q;

endmodule
